// File: rtl/bj_pkg.sv
// Shared types, constants and card helper for the BlackJack round controller.
package bj_pkg;

  localparam int unsigned CARD_W     = 5;
  localparam int unsigned RES_W      = 5;
  localparam int unsigned BUST_LIMIT = 21;
  localparam int unsigned ACE_BONUS  = 10;

  // Result vector bit positions
  localparam int unsigned RES_PWIN  = 0;
  localparam int unsigned RES_DWIN  = 1;
  localparam int unsigned RES_PUSH  = 2;
  localparam int unsigned RES_PBUST = 3;
  localparam int unsigned RES_DBUST = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DEAL2  = 3'd1,
    PLAYER = 3'd2,
    DEALER = 3'd3,
    RESULT = 3'd4
  } state_t;

  // Map a raw counter value onto a legal card: 0 reads as an ace, faces clamp to 10.
  function automatic logic [CARD_W-1:0] sanitize_card(input logic [CARD_W-1:0] card);
    if (card == '0) begin
      return CARD_W'(1);
    end else if (card > CARD_W'(10)) begin
      return CARD_W'(10);
    end else begin
      return card;
    end
  endfunction

endpackage

// File: rtl/bj_hand_accum.sv
// One BlackJack hand: hard sum, ace flag and registered effective total/bust.
module bj_hand_accum
  import bj_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add,
  input  logic [CARD_W-1:0] card,
  output logic [CARD_W-1:0] hard_sum,
  output logic              ace,
  output logic [CARD_W-1:0] total,
  output logic              bust
);

  logic [CARD_W-1:0] card_s;
  logic [CARD_W-1:0] hard_nxt;
  logic [CARD_W:0]   soft_nxt;
  logic [CARD_W-1:0] total_nxt;
  logic              ace_nxt;

  // Next hand value; clear and add together start a fresh hand with one card.
  always_comb begin
    card_s   = sanitize_card(card);
    hard_nxt = hard_sum;
    ace_nxt  = ace;
    if (clear) begin
      hard_nxt = '0;
      ace_nxt  = 1'b0;
    end
    if (add) begin
      hard_nxt = hard_nxt + card_s;
      ace_nxt  = ace_nxt | (card_s == CARD_W'(1));
    end
    // One extra bit so a large hard sum plus the ace bonus cannot wrap.
    soft_nxt  = {1'b0, hard_nxt} + (CARD_W+1)'(ACE_BONUS);
    total_nxt = (ace_nxt && (soft_nxt <= (CARD_W+1)'(BUST_LIMIT)))
                ? soft_nxt[CARD_W-1:0] : hard_nxt;
  end

  // Hand registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hard_sum <= '0;
      ace      <= 1'b0;
      total    <= '0;
      bust     <= 1'b0;
    end else begin
      hard_sum <= hard_nxt;
      ace      <= ace_nxt;
      total    <= total_nxt;
      bust     <= (hard_nxt > CARD_W'(BUST_LIMIT));
    end
  end

endmodule

// File: rtl/bj_round_ctrl.sv
// BlackJack round controller: deal, player turn, dealer auto-draw, settle.
module bj_round_ctrl
  import bj_pkg::*;
#(
  parameter int unsigned DRAW_GAP     = 4,
  parameter int unsigned DEALER_STAND = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              deal,
  input  logic              hit,
  input  logic              stand,
  input  logic [CARD_W-1:0] player_card,
  input  logic [CARD_W-1:0] dealer_card,
  output logic [CARD_W-1:0] player_total,
  output logic [CARD_W-1:0] dealer_total,
  output logic [RES_W-1:0]  result,
  output logic [2:0]        phase
);

  localparam int unsigned GAP_W     = (DRAW_GAP > 1) ? $clog2(DRAW_GAP) : 1;
  localparam int unsigned BTN_DEAL  = 0;
  localparam int unsigned BTN_HIT   = 1;
  localparam int unsigned BTN_STAND = 2;

  state_t            state, state_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic [RES_W-1:0]  result_nxt;
  logic [2:0]        btn_sync, btn_prev, btn_edge;
  logic              gap_done;
  logic              p_clear, p_add, d_clear, d_add;
  logic [CARD_W-1:0] p_hard, d_hard, p_total, d_total;
  logic              p_ace, d_ace, p_bust, d_bust;
  logic              hand_unused;

  // Compare two standing hands; exactly one of win/lose/push is set.
  function automatic logic [RES_W-1:0] settle(input logic [CARD_W-1:0] p,
                                               input logic [CARD_W-1:0] d);
    logic [RES_W-1:0] r;
    r = '0;
    if (p > d) begin
      r[RES_PWIN] = 1'b1;
    end else if (d > p) begin
      r[RES_DWIN] = 1'b1;
    end else begin
      r[RES_PUSH] = 1'b1;
    end
    return r;
  endfunction

  assign btn_edge    = btn_sync & ~btn_prev;
  assign gap_done    = (gap_cnt == '0);
  assign hand_unused = ^{p_hard, p_ace, d_hard, d_ace};

  // Button synchroniser and edge-detect flops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_sync <= '0;
      btn_prev <= '0;
    end else begin
      btn_sync <= {stand, hit, deal};
      btn_prev <= btn_sync;
    end
  end

  // State, gap counter and result registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
      result  <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_nxt;
      result  <= result_nxt;
    end
  end

  // Next-state, hand strobes, gap counter and result decisions
  always_comb begin
    state_nxt  = state;
    result_nxt = result;
    gap_nxt    = gap_done ? gap_cnt : gap_cnt - GAP_W'(1);
    p_clear    = 1'b0;
    p_add      = 1'b0;
    d_clear    = 1'b0;
    d_add      = 1'b0;
    case (state)
      IDLE, RESULT: begin
        if (btn_edge[BTN_DEAL]) begin
          result_nxt = '0;
          p_clear    = 1'b1;
          p_add      = 1'b1;
          d_clear    = 1'b1;
          d_add      = 1'b1;
          gap_nxt    = GAP_W'(DRAW_GAP - 1);
          state_nxt  = DEAL2;
        end
      end
      DEAL2: begin
        if (gap_done) begin
          p_add     = 1'b1;
          d_add     = 1'b1;
          state_nxt = PLAYER;
        end
      end
      PLAYER: begin
        if (p_bust) begin
          result_nxt            = '0;
          result_nxt[RES_PBUST] = 1'b1;
          result_nxt[RES_DWIN]  = 1'b1;
          state_nxt             = RESULT;
        end else if (btn_edge[BTN_STAND]) begin
          gap_nxt   = GAP_W'(DRAW_GAP - 1);
          state_nxt = DEALER;
        end else if (btn_edge[BTN_HIT] && (p_total < CARD_W'(BUST_LIMIT))) begin
          p_add = 1'b1;
        end
      end
      DEALER: begin
        if (d_bust) begin
          result_nxt            = '0;
          result_nxt[RES_DBUST] = 1'b1;
          result_nxt[RES_PWIN]  = 1'b1;
          state_nxt             = RESULT;
        end else if (gap_done) begin
          if (d_total < CARD_W'(DEALER_STAND)) begin
            d_add   = 1'b1;
            gap_nxt = GAP_W'(DRAW_GAP - 1);
          end else begin
            result_nxt = settle(p_total, d_total);
            state_nxt  = RESULT;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  bj_hand_accum u_player (
    .clock    (clock),
    .reset    (reset),
    .clear    (p_clear),
    .add      (p_add),
    .card     (player_card),
    .hard_sum (p_hard),
    .ace      (p_ace),
    .total    (p_total),
    .bust     (p_bust)
  );

  bj_hand_accum u_dealer (
    .clock    (clock),
    .reset    (reset),
    .clear    (d_clear),
    .add      (d_add),
    .card     (dealer_card),
    .hard_sum (d_hard),
    .ace      (d_ace),
    .total    (d_total),
    .bust     (d_bust)
  );

  assign player_total = p_total;
  assign dealer_total = d_total;
  assign phase        = state;

endmodule

// File: tb/tb_bj_round_ctrl.sv
// Scoreboard bench for bj_round_ctrl: rounds are modelled as card lists,
// expectations queued at issue time, a monitor checks on phase changes.
module tb_bj_round_ctrl;
  import bj_pkg::*;

  localparam int unsigned TB_GAP   = 4;
  localparam int unsigned TB_STAND = 17;

  logic       clock = 1'b0;
  logic       reset;
  logic       deal, hit, stand;
  logic [4:0] player_card, dealer_card;
  logic [4:0] player_total, dealer_total;
  logic [4:0] result;
  logic [2:0] phase;

  typedef struct {
    int p_deal;
    int d_deal;
    int p_fin;
    int d_fin;
    int res;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  logic [2:0] prev_phase = 3'd0;

  bj_round_ctrl #(.DRAW_GAP(TB_GAP), .DEALER_STAND(TB_STAND)) dut (
    .clock        (clock),
    .reset        (reset),
    .deal         (deal),
    .hit          (hit),
    .stand        (stand),
    .player_card  (player_card),
    .dealer_card  (dealer_card),
    .player_total (player_total),
    .dealer_total (dealer_total),
    .result       (result),
    .phase        (phase)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: a hand is just the list of card values drawn.
  function automatic int card_val(input int raw);
    if (raw == 0) return 1;
    if (raw > 10) return 10;
    return raw;
  endfunction

  function automatic int hand_total(input int cards[$]);
    int s = 0;
    bit has_ace = 1'b0;
    foreach (cards[i]) begin
      s += cards[i];
      if (cards[i] == 1) has_ace = 1'b1;
    end
    return (has_ace && (s + 10 <= 21)) ? s + 10 : s;
  endfunction

  function automatic int rand_card();
    int r = int'($urandom_range(0, 19));
    if (r < 16) return (r % 10) + 1;
    if (r == 16) return 0;
    return int'($urandom_range(11, 31));
  endfunction

  task automatic wait_phase(input logic [2:0] tgt, input int budget);
    int n = 0;
    while (phase !== tgt && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (phase !== tgt) check("phase_timeout", int'(phase), int'(tgt));
  endtask

  task automatic pulse(input bit d, input bit h, input bit s);
    @(negedge clock);
    deal = d; hit = h; stand = s;
    repeat (2) @(negedge clock);
    deal = 1'b0; hit = 1'b0; stand = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Play one round: model it, queue the expectation, then drive it.
  task automatic run_round(input int p1, input int p2, input int d1, input int d2,
                           input int hq[$], input bit both, input int dr);
    int   ph[$];
    int   dh[$];
    int   nissue;
    bit   pbust;
    exp_t e;
    ph = '{card_val(p1), card_val(p2)};
    dh = '{card_val(d1), card_val(d2)};
    e.p_deal = hand_total(ph);
    e.d_deal = hand_total(dh);
    pbust  = 1'b0;
    nissue = 0;
    foreach (hq[i]) begin
      if (pbust) break;
      if (hand_total(ph) < 21) ph.push_back(card_val(hq[i]));
      if (hand_total(ph) > 21) pbust = 1'b1;
      nissue++;
    end
    if (!pbust) begin
      while (hand_total(dh) < TB_STAND) dh.push_back(card_val(dr));
    end
    e.p_fin = hand_total(ph);
    e.d_fin = hand_total(dh);
    if (pbust)                 e.res = 5'b01010;
    else if (e.d_fin > 21)     e.res = 5'b10001;
    else if (e.p_fin > e.d_fin) e.res = 5'b00001;
    else if (e.d_fin > e.p_fin) e.res = 5'b00010;
    else                       e.res = 5'b00100;
    sb_q.push_back(e);

    @(negedge clock);
    player_card = 5'(p1);
    dealer_card = 5'(d1);
    deal = 1'b1;
    wait_phase(DEAL2, 10);
    player_card = 5'(p2);
    dealer_card = 5'(d2);
    wait_phase(PLAYER, 20);
    deal = 1'b0;
    repeat (2) @(negedge clock);
    for (int i = 0; i < nissue; i++) begin
      player_card = 5'(hq[i]);
      pulse(1'b0, 1'b1, 1'b0);
    end
    if (!pbust) begin
      dealer_card = 5'(dr);
      player_card = 5'(rand_card());
      pulse(1'b0, both, 1'b1);
    end
    wait_phase(RESULT, 200);
    repeat (2) @(negedge clock);
  endtask

  // Monitor: check deal totals on entering PLAYER, final outcome on entering RESULT.
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (phase == PLAYER && prev_phase != PLAYER) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow_deal", 1, 0);
        end else begin
          e = sb_q[0];
          check("deal_ptotal", int'(player_total), e.p_deal);
          check("deal_dtotal", int'(dealer_total), e.d_deal);
        end
      end
      if (phase == RESULT && prev_phase != RESULT) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow_result", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("result", int'(result), e.res);
          check("fin_ptotal", int'(player_total), e.p_fin);
          check("fin_dtotal", int'(dealer_total), e.d_fin);
        end
      end
      if (phase != RESULT && result != 5'd0) check("result_zero", int'(result), 0);
    end
    prev_phase = phase;
  end

  initial begin
    int hq[$];
    reset = 1'b1;
    deal = 1'b0; hit = 1'b0; stand = 1'b0;
    player_card = 5'd1; dealer_card = 5'd1;
    repeat (3) @(negedge clock);
    check("rst_ptotal", int'(player_total), 0);
    check("rst_dtotal", int'(dealer_total), 0);
    check("rst_result", int'(result), 0);
    check("rst_phase", int'(phase), int'(IDLE));
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Reset during the dealer's draw sequence aborts the round.
    player_card = 5'd2; dealer_card = 5'd2;
    pulse(1'b1, 1'b0, 1'b0);
    wait_phase(PLAYER, 20);
    pulse(1'b0, 1'b0, 1'b1);
    wait_phase(DEALER, 20);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_phase", int'(phase), int'(IDLE));
    check("abort_ptotal", int'(player_total), 0);
    check("abort_dtotal", int'(dealer_total), 0);
    check("abort_result", int'(result), 0);
    @(negedge clock);
    reset = 1'b0;
    pulse(1'b0, 1'b1, 1'b0);
    check("idle_hit_phase", int'(phase), int'(IDLE));
    check("idle_hit_ptotal", int'(player_total), 0);
    mon_en = 1'b1;

    // Directed rounds
    hq = {};
    run_round(10, 10, 6, 6, hq, 1'b0, 6);          // 20 vs 18
    hq = '{9, 5};
    run_round(1, 1, 10, 7, hq, 1'b0, 3);           // soft 12 -> 21, extra hit ignored
    hq = '{5};
    run_round(10, 10, 9, 8, hq, 1'b0, 2);          // player bust at 25
    hq = {};
    run_round(10, 10, 10, 10, hq, 1'b1, 4);        // push 20, hit+stand together
    hq = '{8};
    run_round(10, 0, 6, 10, hq, 1'b0, 10);         // dealer 16 + 10 busts
    hq = {};
    run_round(31, 10, 1, 6, hq, 1'b0, 5);          // dealer soft 17 stands

    // Randomised rounds
    for (int r = 0; r < 40; r++) begin
      int n;
      hq = {};
      n = int'($urandom_range(0, 4));
      for (int k = 0; k < n; k++) hq.push_back(rand_card());
      run_round(rand_card(), rand_card(), rand_card(), rand_card(), hq,
                bit'($urandom_range(0, 3) == 0), rand_card());
    end

    repeat (3) @(negedge clock);
    check("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
